// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
// Load/store unit sitting after the ALU. It accepts one memory instruction at
// a time, rejects illegal or misaligned requests up front, runs a single
// req/ack transaction on the data bus otherwise, and returns formatted load
// data (or an error code) as a one-cycle response.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake from execute (ready only in IDLE)
//   is_store, funct3    operation type and RV32I width/sign selector
//   addr, wdata         effective address and store data (rs2)
//   resp_valid          one-cycle completion pulse
//   rdata, err, err_code  formatted load data and status, held until next response
//   dmem_*              data-memory bus (req held until ack or timeout)
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [3:0]  dmem_be_q, dmem_be_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;

    function automatic logic f3_legal(input logic st, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !st;  // unsigned variants are load-only
            default:                f3_legal = 1'b0;
        endcase
    endfunction

    // funct3[1:0] encodes the width for both signed and unsigned forms.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        misaligned = ((f3[1:0] == 2'b01) && a[0]) ||
                     ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   byte_en = 4'b0001 << a;
            2'b01:   byte_en = 4'b0011 << a;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data into every lane; byte enables pick the lane.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_lanes = {4{d[7:0]}};
            2'b01:   store_lanes = {2{d[15:0]}};
            default: store_lanes = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {a, 3'b000};
        case (f3)
            3'b000:  load_fmt = {{24{sh[7]}}, sh[7:0]};
            3'b001:  load_fmt = {{16{sh[15]}}, sh[15:0]};
            3'b100:  load_fmt = {24'd0, sh[7:0]};
            3'b101:  load_fmt = {16'd0, sh[15:0]};
            default: load_fmt = word;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_store_d   = is_store_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        rdata_d      = rdata_q;
        err_code_d   = err_code_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    off_d      = addr[1:0];
                    if (!f3_legal(is_store, funct3)) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        err_code_d   = 2'b10;
                        rdata_d      = 32'd0;
                    end else if (misaligned(funct3, addr[1:0])) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        err_code_d   = 2'b01;
                        rdata_d      = 32'd0;
                    end else begin
                        state_d      = S_BUS;
                        cnt_d        = 8'd0;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_be_d    = byte_en(funct3, addr[1:0]);
                        dmem_addr_d  = {addr[31:2], 2'b00};
                        dmem_wdata_d = is_store ? store_lanes(funct3, wdata) : 32'd0;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + 8'd1;
                // Ack is checked first so an ack on the last allowed cycle still succeeds.
                if (dmem_ack) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    err_code_d   = 2'b00;
                    rdata_d      = is_store_q ? 32'd0 : load_fmt(funct3_q, off_q, dmem_rdata);
                end else if ((32'(cnt_q) + 32'd1) >= TIMEOUT) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    err_code_d   = 2'b11;
                    rdata_d      = 32'd0;
                end
                if (state_d == S_RESP) begin
                    dmem_req_d   = 1'b0;
                    dmem_we_d    = 1'b0;
                    dmem_be_d    = 4'b0000;
                    dmem_addr_d  = 32'd0;
                    dmem_wdata_d = 32'd0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            resp_valid_q <= 1'b0;
            rdata_q      <= 32'd0;
            err_code_q   <= 2'b00;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'b0000;
            dmem_addr_q  <= 32'd0;
            dmem_wdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_store_q   <= is_store_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
            err_code_q   <= err_code_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err_code   = err_code_q;
    assign err        = (err_code_q != 2'b00);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage with a response scoreboard.
module tb_lsu_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  err_code;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    lsu_mem_stage #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err),
        .err_code   (err_code),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_exp    = 0;
    int   n_resp   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            n_resp++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp: got rdata=0x%08h err_code=%0d with no expectation",
                         rdata, err_code);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("resp_rdata", rdata, e.rdata);
                chk("resp_err", 32'(err), 32'(e.err));
                chk("resp_code", 32'(err_code), 32'(e.code));
            end
        end
    end

    task automatic expect_resp(input logic [31:0] rd, input logic e, input logic [1:0] c);
        exp_t x;
        x.rdata = rd;
        x.err   = e;
        x.code  = c;
        sb_q.push_back(x);
        n_exp++;
    endtask

    // Presents a request for one cycle; returns #1 after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_bus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd, input int waits,
                           input logic [31:0] rd, input logic [31:0] exp_rd);
        expect_resp(exp_rd, 1'b0, 2'b00);
        issue(st, f3, a, wd);
        chk("dmem_req_on", 32'(dmem_req), 32'd1);
        chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
        chk("dmem_be", 32'(dmem_be), 32'(exp_be));
        chk("dmem_we", 32'(dmem_we), 32'(st));
        if (st) chk("dmem_wdata", dmem_wdata, exp_wd);
        for (int i = 0; i < waits; i++) begin
            @(posedge clk);
            #1;
            chk("dmem_req_hold", 32'(dmem_req), 32'd1);
            chk("dmem_be_hold", 32'(dmem_be), 32'(exp_be));
        end
        dmem_ack   = 1'b1;
        dmem_rdata = rd;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk("resp_latency", 32'(resp_valid), 32'd1);
        chk("dmem_req_off", 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    task automatic run_err(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [1:0] code);
        expect_resp(32'd0, 1'b1, code);
        issue(st, f3, a, 32'hFFFF_FFFF);
        chk("err_resp_next", 32'(resp_valid), 32'd1);
        chk("err_no_req", 32'(dmem_req), 32'd0);
        @(posedge clk);
        #1;
        chk("err_no_req_after", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'd0;
        wdata      = 32'd0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_be", 32'(dmem_be), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // st, f3, addr, wdata, be, bus wdata, waits, bus rdata, expected rdata
        run_bus(1'b0, 3'b010, 32'h0000_1004, 32'd0, 4'b1111, 32'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_bus(1'b0, 3'b000, 32'h0000_1003, 32'd0, 4'b1000, 32'd0, 0, 32'h8012_3456, 32'hFFFF_FF80);
        run_bus(1'b0, 3'b100, 32'h0000_1003, 32'd0, 4'b1000, 32'd0, 1, 32'h8012_3456, 32'h0000_0080);
        run_bus(1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 3, 32'h5555_5555, 32'd0);
        run_bus(1'b0, 3'b001, 32'h0000_1002, 32'd0, 4'b1100, 32'd0, 0, 32'h8012_3456, 32'hFFFF_8012);
        run_bus(1'b0, 3'b101, 32'h0000_1000, 32'd0, 4'b0011, 32'd0, 2, 32'h1234_F00F, 32'h0000_F00F);
        run_bus(1'b1, 3'b000, 32'h0000_2001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 0, 32'd0, 32'd0);
        run_bus(1'b1, 3'b010, 32'h0000_2004, 32'h1122_3344, 4'b1111, 32'h1122_3344, 1, 32'd0, 32'd0);

        // st, f3, addr, err_code
        run_err(1'b0, 3'b010, 32'h0000_1001, 2'b01);
        run_err(1'b0, 3'b011, 32'h0000_1000, 2'b10);
        run_err(1'b1, 3'b100, 32'h0000_1000, 2'b10);
        run_err(1'b1, 3'b101, 32'h0000_1001, 2'b10);
        run_err(1'b0, 3'b001, 32'h0000_1003, 2'b01);

        // Timeout with TIMEOUT=4, then a stray ack that must be ignored.
        expect_resp(32'd0, 1'b1, 2'b11);
        issue(1'b0, 3'b010, 32'h0000_3000, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("to_req_high", 32'(dmem_req), 32'd1);
            @(posedge clk);
            #1;
        end
        chk("to_req_low", 32'(dmem_req), 32'd0);
        chk("to_resp", 32'(resp_valid), 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'd0;
        chk("stray_no_resp", 32'(resp_valid), 32'd0);
        chk("stray_no_req", 32'(dmem_req), 32'd0);
        chk("stray_ready", 32'(req_ready), 32'd1);

        // Reset while the bus transaction is outstanding: no response.
        issue(1'b0, 3'b010, 32'h0000_1008, 32'd0);
        chk("abort_req_on", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_req_off", 32'(dmem_req), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_no_resp2", 32'(resp_valid), 32'd0);

        // Accepting works again after the abort.
        run_bus(1'b0, 3'b010, 32'h0000_100C, 32'd0, 4'b1111, 32'd0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("resp_count", 32'(n_resp), 32'(n_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store unit for the RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It runs one data-memory transaction per instruction over a req/ack bus and returns sign- or zero-extended load data to the writeback stage. Misaligned accesses, illegal funct3 values and bus timeouts are reported instead of reaching memory.

## Interface
Parameters:
- TIMEOUT, default 255: maximum cycles to wait for dmem_ack after dmem_req rises; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  execute stage presents a memory instruction.
- req_ready  out  1  LSU can accept; high only in IDLE.
- is_store  in  1  1 = store (SB/SH/SW), 0 = load.
- funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  32  effective address (ALU output).
- wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle pulse; the operation is complete.
- rdata  out  32  formatted load data; 0 for stores and errors.
- err  out  1  qualifies resp_valid; the operation failed.
- err_code  out  2  01 misaligned, 10 illegal funct3, 11 timeout, 00 none.
- dmem_req  out  1  bus request; held until ack or timeout.
- dmem_we  out  1  write enable.
- dmem_be  out  4  byte enables.
- dmem_addr  out  32  word address, {addr[31:2],2'b00}.
- dmem_wdata  out  32  store data replicated into lanes.
- dmem_ack  in  1  bus completion; single-cycle pulse.
- dmem_rdata  in  32  read word; valid in the ack cycle.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. If req_valid=1, latch is_store, funct3, addr, wdata and check the request:
  - Illegal funct3: loads allow 000/001/010/100/101; stores allow 000/001/010. Otherwise go to RESP with err_code=10.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with err_code=01.
  - Illegal takes priority over misaligned.
  - Otherwise go to BUS, clear the timeout counter, and drive the bus outputs from the next cycle.
- BUS: dmem_req=1, with dmem_we, dmem_be, dmem_addr and dmem_wdata stable for the whole state.
  - The counter increments each cycle.
  - If dmem_ack=1, capture dmem_rdata and go to RESP with err_code=00.
  - Else if the counter has reached TIMEOUT, go to RESP with err_code=11.
  - Ack and the timeout limit in the same cycle: ack wins.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE.
- Byte enables:
  - B: 0001 << addr[1:0].
  - H: 0011 << addr[1:0].
  - W: 1111.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load formatting: select the byte or halfword lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- rdata is 0 for stores and errors. err=1 iff err_code!=00.
- dmem_ack outside BUS is ignored. A late ack after a timeout is discarded.

## Timing
- Reset (rst_n=0 at an edge): state becomes IDLE and counter 0.
  - On the following cycle: req_ready=1; resp_valid, err, dmem_req and dmem_we are 0; err_code=00; dmem_be=0000; rdata, dmem_addr and dmem_wdata are 0.
  - Reset in BUS or RESP aborts the operation; no resp_valid is produced.
- Accept at edge T (IDLE, req_valid=1): dmem_req=1 during cycle T+1.
- Ack sampled at edge T+1+k (k≥0 wait cycles): resp_valid=1 during cycle T+2+k. Minimum latency is 2 cycles.
- Error detected at accept: resp_valid=1 during cycle T+1; dmem_req stays 0.
- Timeout: dmem_req is high for TIMEOUT cycles; resp_valid follows in the next cycle.
- req_valid is ignored while req_ready=0. The next request can be accepted in the cycle after resp_valid.
- rdata, err and err_code are valid only with resp_valid, and held until the next response.

## Test plan
- LW, addr=0x0000_1004, ack after 0 waits with dmem_rdata=0xDEAD_BEEF:
  - dmem_addr=0x1004, dmem_be=1111, dmem_we=0.
  - resp_valid 2 cycles after accept, rdata=0xDEAD_BEEF, err=0.
- LB, addr=0x1003, dmem_rdata=0x8012_3456:
  - dmem_be=1000, rdata=0xFFFF_FF80.
  - Same with LBU: rdata=0x0000_0080.
- SH, addr=0x2002, wdata=0x1234_ABCD, ack after 3 waits:
  - dmem_we=1, dmem_be=1100, dmem_wdata=0xABCD_ABCD.
  - dmem_req high 4 cycles, then resp_valid with rdata=0.
- LW, addr=0x1001:
  - no dmem_req.
  - resp_valid next cycle, err=1, err_code=01.
- Load funct3=011:
  - err_code=10, no bus activity.
- TIMEOUT=4, no ack:
  - dmem_req high 4 cycles, then resp_valid with err_code=11.
  - A stray ack one cycle later is ignored.
- Reset asserted mid-BUS:
  - dmem_req=0 and req_ready=1 next cycle, no resp_valid.
